mmu_translator: RTL and testbench

Address-translating memory management unit between two virtual-address clients and one physical memory port. Each accepted virtual request triggers one page-table read, then one data access at the translated physical address. Read data is returned to the originating client. Only one transaction is in flight at a time, and the two clients are arbitrated round-robin.

---
 rtl/mmu_translator.sv | 165 ++++++++++++++++
 tb/tb_mmu_translator.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_translator.sv
// rtl/mmu_translator.sv - two-client virtual-to-physical translating MMU
//
// Purpose: accepts one virtual request at a time from two clients (round-robin),
// reads the client's page-table entry from physical memory, then performs the
// data access at the translated address and returns read data to the client.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   vir_mem_reqs_*   [1:0]      client requests (valid, is_write, data, addr)
//   vir_mem_req_grants [1:0]    request accept, combinational in IDLE
//   vir_mem_resps_*  [1:0]      read responses (valid, data)
//   vir_mem_resp_grants [1:0]   client consumed the response
//   phy_mem_reqs_*              physical memory request (valid, is_write, data, addr)
//   phy_mem_req_grants          memory accepted the request
//   phy_mem_resps_*             physical memory read data (valid, data)
//   phy_mem_resp_grants         MMU accepts the memory response
module mmu_translator #(
    parameter logic [31:0] PT_BASE = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         vir_mem_reqs_valid,
    input  logic [1:0]         vir_mem_reqs_is_write,
    input  logic [1:0][511:0]  vir_mem_reqs_data,
    input  logic [1:0][31:0]   vir_mem_reqs_addr,
    output logic [1:0]         vir_mem_req_grants,
    output logic [1:0]         vir_mem_resps_valid,
    output logic [1:0][511:0]  vir_mem_resps_data,
    input  logic [1:0]         vir_mem_resp_grants,
    output logic               phy_mem_reqs_valid,
    output logic               phy_mem_reqs_is_write,
    output logic [511:0]       phy_mem_reqs_data,
    output logic [31:0]        phy_mem_reqs_addr,
    input  logic               phy_mem_req_grants,
    input  logic               phy_mem_resps_valid,
    input  logic [511:0]       phy_mem_resps_data,
    output logic               phy_mem_resp_grants
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTE_REQ,
        S_PTE_WAIT,
        S_DATA_REQ,
        S_DATA_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic           rr_q, rr_d;          // port holding priority on a tie
    logic           port_q, port_d;
    logic           is_write_q, is_write_d;
    logic [31:0]    addr_q, addr_d;
    logic [511:0]   wdata_q, wdata_d;
    logic [511:0]   rdata_q, rdata_d;
    logic [15:0]    ppn_q, ppn_d;

    logic           pick;
    logic [16:0]    pte_index;
    logic [31:0]    pte_line_addr;
    logic [3:0]     pte_sel;

    // Each client owns half of the page table: the port id is the index MSB.
    assign pte_index     = {port_q, addr_q[31:16]};
    assign pte_line_addr = PT_BASE + {19'd0, pte_index[16:4]};
    assign pte_sel       = pte_index[3:0];

    // With a single requester it wins outright; on a tie the pointer decides.
    assign pick = (&vir_mem_reqs_valid) ? rr_q : vir_mem_reqs_valid[1];

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        port_d     = port_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ppn_d      = ppn_q;

        vir_mem_req_grants    = '0;
        vir_mem_resps_valid   = '0;
        vir_mem_resps_data    = '0;
        phy_mem_reqs_valid    = 1'b0;
        phy_mem_reqs_is_write = 1'b0;
        phy_mem_reqs_data     = '0;
        phy_mem_reqs_addr     = '0;
        phy_mem_resp_grants   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|vir_mem_reqs_valid) begin
                    vir_mem_req_grants[pick] = 1'b1;
                    port_d     = pick;
                    is_write_d = vir_mem_reqs_is_write[pick];
                    addr_d     = vir_mem_reqs_addr[pick];
                    wdata_d    = vir_mem_reqs_data[pick];
                    rr_d       = ~pick;
                    state_d    = S_PTE_REQ;
                end
            end
            S_PTE_REQ: begin
                phy_mem_reqs_valid = 1'b1;
                phy_mem_reqs_addr  = pte_line_addr;
                if (phy_mem_req_grants) begin
                    state_d = S_PTE_WAIT;
                end
            end
            S_PTE_WAIT: begin
                phy_mem_resp_grants = 1'b1;
                if (phy_mem_resps_valid) begin
                    ppn_d   = phy_mem_resps_data[{pte_sel, 5'd0} +: 16];
                    state_d = S_DATA_REQ;
                end
            end
            S_DATA_REQ: begin
                phy_mem_reqs_valid    = 1'b1;
                phy_mem_reqs_is_write = is_write_q;
                phy_mem_reqs_addr     = {ppn_q, addr_q[15:0]};
                phy_mem_reqs_data     = wdata_q;
                if (phy_mem_req_grants) begin
                    state_d = is_write_q ? S_IDLE : S_DATA_WAIT;
                end
            end
            S_DATA_WAIT: begin
                phy_mem_resp_grants = 1'b1;
                if (phy_mem_resps_valid) begin
                    rdata_d = phy_mem_resps_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                vir_mem_resps_valid[port_q] = 1'b1;
                vir_mem_resps_data[port_q]  = rdata_q;
                if (vir_mem_resp_grants[port_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            port_q     <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ppn_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            port_q     <= port_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ppn_q      <= ppn_d;
        end
    end

endmodule

// File: tb/tb_mmu_translator.sv
// tb/tb_mmu_translator.sv - self-checking bench for mmu_translator
module tb_mmu_translator;

    localparam logic [31:0] PT_BASE = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         vir_mem_reqs_valid;
    logic [1:0]         vir_mem_reqs_is_write;
    logic [1:0][511:0]  vir_mem_reqs_data;
    logic [1:0][31:0]   vir_mem_reqs_addr;
    logic [1:0]         vir_mem_req_grants;
    logic [1:0]         vir_mem_resps_valid;
    logic [1:0][511:0]  vir_mem_resps_data;
    logic [1:0]         vir_mem_resp_grants;
    logic               phy_mem_reqs_valid;
    logic               phy_mem_reqs_is_write;
    logic [511:0]       phy_mem_reqs_data;
    logic [31:0]        phy_mem_reqs_addr;
    logic               phy_mem_req_grants;
    logic               phy_mem_resps_valid;
    logic [511:0]       phy_mem_resps_data;
    logic               phy_mem_resp_grants;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Behavioural physical memory: line address -> 512-bit line.
    logic [511:0] mem [logic [31:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mmu_translator #(.PT_BASE(PT_BASE)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .vir_mem_reqs_valid    (vir_mem_reqs_valid),
        .vir_mem_reqs_is_write (vir_mem_reqs_is_write),
        .vir_mem_reqs_data     (vir_mem_reqs_data),
        .vir_mem_reqs_addr     (vir_mem_reqs_addr),
        .vir_mem_req_grants    (vir_mem_req_grants),
        .vir_mem_resps_valid   (vir_mem_resps_valid),
        .vir_mem_resps_data    (vir_mem_resps_data),
        .vir_mem_resp_grants   (vir_mem_resp_grants),
        .phy_mem_reqs_valid    (phy_mem_reqs_valid),
        .phy_mem_reqs_is_write (phy_mem_reqs_is_write),
        .phy_mem_reqs_data     (phy_mem_reqs_data),
        .phy_mem_reqs_addr     (phy_mem_reqs_addr),
        .phy_mem_req_grants    (phy_mem_req_grants),
        .phy_mem_resps_valid   (phy_mem_resps_valid),
        .phy_mem_resps_data    (phy_mem_resps_data),
        .phy_mem_resp_grants   (phy_mem_resp_grants)
    );

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [511:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = rand_line();
        return mem[a];
    endfunction

    task automatic idle_inputs();
        vir_mem_reqs_valid    = '0;
        vir_mem_reqs_is_write = '0;
        vir_mem_reqs_data     = '0;
        vir_mem_reqs_addr     = '0;
        vir_mem_resp_grants   = '0;
        phy_mem_req_grants    = 1'b0;
        phy_mem_resps_valid   = 1'b0;
        phy_mem_resps_data    = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered and left just after a falling edge. Plays client p and the
    // physical memory for one transaction; gdly = cycles of stall per handshake.
    task automatic run_txn(input int p, input bit w, input logic [31:0] va,
                           input logic [511:0] wd, input int gdly,
                           input bit stray, input bit abort, output int lat);
        logic [16:0]  idx;
        logic [31:0]  pte_a, pa;
        logic [511:0] line, exp_d;
        int           s, t0;
        bit           got;
        idx   = {p[0], va[31:16]};
        pte_a = PT_BASE + 32'(idx[16:4]);
        s     = int'(idx[3:0]);
        lat   = -1;
        vir_mem_reqs_valid[p]    = 1'b1;
        vir_mem_reqs_is_write[p] = w;
        vir_mem_reqs_addr[p]     = va;
        vir_mem_reqs_data[p]     = wd;
        #1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (vir_mem_req_grants[p]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL accept_p%0d: grant=%b required bit %0d set", p, vir_mem_req_grants, p);
            vir_mem_reqs_valid[p] = 1'b0;
            return;
        end
        n_cmp++;
        if (vir_mem_req_grants[1-p] !== 1'b0) begin
            n_err++;
            $display("FAIL grant_other_p%0d: grant=%b required only bit %0d", p, vir_mem_req_grants, p);
        end
        t0 = cyc;
        @(negedge clk);
        vir_mem_reqs_valid[p] = 1'b0;
        #1;
        for (int k = 0; k <= gdly; k++) begin
            if (stray && k == 0) begin
                phy_mem_resps_valid = 1'b1;
                phy_mem_resps_data  = rand_line();
                #1;
            end
            n_cmp++;
            if (phy_mem_reqs_valid !== 1'b1 || phy_mem_reqs_is_write !== 1'b0 || phy_mem_reqs_addr !== pte_a) begin
                n_err++;
                $display("FAIL pte_req: v=%b w=%b addr=%h required v=1 w=0 addr=%h", phy_mem_reqs_valid, phy_mem_reqs_is_write, phy_mem_reqs_addr, pte_a);
            end
            n_cmp++;
            if (phy_mem_resp_grants !== 1'b0 || vir_mem_req_grants !== 2'b00) begin
                n_err++;
                $display("FAIL pte_req_idle_grants: resp_grant=%b req_grants=%b required 0 and 00", phy_mem_resp_grants, vir_mem_req_grants);
            end
            if (k == gdly) phy_mem_req_grants = 1'b1;
            @(negedge clk);
            phy_mem_req_grants  = 1'b0;
            phy_mem_resps_valid = 1'b0;
            #1;
        end
        for (int k = 0; k <= gdly; k++) begin
            n_cmp++;
            if (phy_mem_resp_grants !== 1'b1 || phy_mem_reqs_valid !== 1'b0) begin
                n_err++;
                $display("FAIL pte_wait: resp_grant=%b req_valid=%b required 1 and 0", phy_mem_resp_grants, phy_mem_reqs_valid);
            end
            if (k == gdly) begin
                phy_mem_resps_valid = 1'b1;
                phy_mem_resps_data  = mem_rd(pte_a);
            end
            @(negedge clk);
            phy_mem_resps_valid = 1'b0;
            phy_mem_resps_data  = '0;
            #1;
        end
        line = mem_rd(pte_a);
        pa   = {line[32*s +: 16], va[15:0]};
        for (int k = 0; k <= gdly; k++) begin
            n_cmp++;
            if (phy_mem_reqs_valid !== 1'b1 || phy_mem_reqs_is_write !== w || phy_mem_reqs_addr !== pa || phy_mem_reqs_data !== wd) begin
                n_err++;
                $display("FAIL data_req: v=%b w=%b addr=%h d[31:0]=%h required v=1 w=%b addr=%h d[31:0]=%h", phy_mem_reqs_valid, phy_mem_reqs_is_write, phy_mem_reqs_addr, phy_mem_reqs_data[31:0], w, pa, wd[31:0]);
            end
            if (k == gdly) phy_mem_req_grants = 1'b1;
            @(negedge clk);
            phy_mem_req_grants = 1'b0;
            #1;
        end
        if (w) begin
            mem[pa] = wd;
            n_cmp++;
            if (phy_mem_reqs_valid !== 1'b0 || phy_mem_resp_grants !== 1'b0 || vir_mem_resps_valid !== 2'b00) begin
                n_err++;
                $display("FAIL write_done: req_v=%b resp_grant=%b vresp_v=%b required 0 0 00", phy_mem_reqs_valid, phy_mem_resp_grants, vir_mem_resps_valid);
            end
            lat = 0;
            return;
        end
        exp_d = mem_rd(pa);
        for (int k = 0; k <= gdly; k++) begin
            n_cmp++;
            if (phy_mem_resp_grants !== 1'b1 || phy_mem_reqs_valid !== 1'b0) begin
                n_err++;
                $display("FAIL data_wait: resp_grant=%b req_valid=%b required 1 and 0", phy_mem_resp_grants, phy_mem_reqs_valid);
            end
            if (abort) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                n_cmp++;
                if (vir_mem_req_grants !== 2'b00 || vir_mem_resps_valid !== 2'b00 || vir_mem_resps_data !== '0 ||
                    phy_mem_reqs_valid !== 1'b0 || phy_mem_reqs_is_write !== 1'b0 || phy_mem_reqs_addr !== '0 ||
                    phy_mem_reqs_data !== '0 || phy_mem_resp_grants !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_outputs: vg=%b vv=%b pv=%b pw=%b pa=%h prg=%b required all zero", vir_mem_req_grants, vir_mem_resps_valid, phy_mem_reqs_valid, phy_mem_reqs_is_write, phy_mem_reqs_addr, phy_mem_resp_grants);
                end
                phy_mem_resps_valid = 1'b1;
                phy_mem_resps_data  = exp_d;
                #1;
                n_cmp++;
                if (phy_mem_resp_grants !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_late_resp_grant: resp_grant=%b required 0", phy_mem_resp_grants);
                end
                @(negedge clk);
                phy_mem_resps_valid = 1'b0;
                phy_mem_resps_data  = '0;
                #1;
                n_cmp++;
                if (vir_mem_resps_valid !== 2'b00 || phy_mem_reqs_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_after_pulse: vresp_v=%b req_v=%b required 00 and 0", vir_mem_resps_valid, phy_mem_reqs_valid);
                end
                return;
            end
            if (k == gdly) begin
                phy_mem_resps_valid = 1'b1;
                phy_mem_resps_data  = exp_d;
            end
            @(negedge clk);
            phy_mem_resps_valid = 1'b0;
            phy_mem_resps_data  = '0;
            #1;
        end
        lat = cyc - t0;
        if (gdly == 0) begin
            n_cmp++;
            if (lat != 5) begin
                n_err++;
                $display("FAIL read_latency: %0d cycles required 5", lat);
            end
        end
        for (int k = 0; k <= gdly; k++) begin
            n_cmp++;
            if (vir_mem_resps_valid !== (2'b01 << p) || vir_mem_resps_data[p] !== exp_d) begin
                n_err++;
                $display("FAIL resp_p%0d: valid=%b d[31:0]=%h required valid=%b d[31:0]=%h", p, vir_mem_resps_valid, vir_mem_resps_data[p][31:0], 2'b01 << p, exp_d[31:0]);
            end
            if (k == gdly) vir_mem_resp_grants[p] = 1'b1;
            @(negedge clk);
            vir_mem_resp_grants = '0;
            #1;
        end
        n_cmp++;
        if (vir_mem_resps_valid !== 2'b00) begin
            n_err++;
            $display("FAIL resp_drop_p%0d: valid=%b required 00", p, vir_mem_resps_valid);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if (vir_mem_req_grants !== 2'b00 || vir_mem_resps_valid !== 2'b00 || vir_mem_resps_data !== '0 ||
            phy_mem_reqs_valid !== 1'b0 || phy_mem_reqs_is_write !== 1'b0 || phy_mem_reqs_addr !== '0 ||
            phy_mem_reqs_data !== '0 || phy_mem_resp_grants !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: vg=%b vv=%b pv=%b pa=%h prg=%b required all zero", vir_mem_req_grants, vir_mem_resps_valid, phy_mem_reqs_valid, phy_mem_reqs_addr, phy_mem_resp_grants);
        end
        @(negedge clk);
    endtask

    task automatic test_read_translation();
        logic [511:0] line;
        int lat;
        line = rand_line();
        line[96 +: 32] = 32'h0000_0042;
        mem[PT_BASE] = line;
        mem[32'h0042_0003] = 512'd98;
        run_txn(0, 1'b0, 32'h0003_0003, rand_line(), 0, 1'b0, 1'b0, lat);
        run_txn(0, 1'b0, 32'h0003_0003, rand_line(), 3, 1'b0, 1'b0, lat);
    endtask

    task automatic test_write_translation();
        logic [511:0] line;
        int lat;
        line = rand_line();
        line[160 +: 32] = 32'hDEAD_0007;
        mem[PT_BASE + 32'h1000] = line;
        run_txn(1, 1'b1, 32'h0005_0010, 512'hAB, 1, 1'b0, 1'b0, lat);
        run_txn(1, 1'b0, 32'h0005_0010, '0, 0, 1'b0, 1'b0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        apply_reset();
        vir_mem_reqs_valid[1]    = 1'b1;
        vir_mem_reqs_is_write[1] = 1'b0;
        vir_mem_reqs_addr[1]     = 32'h0011_2222;
        vir_mem_reqs_data[1]     = '0;
        run_txn(0, 1'b0, 32'h0022_3333, '0, 1, 1'b0, 1'b0, lat);
        vir_mem_reqs_valid[0]    = 1'b1;
        vir_mem_reqs_is_write[0] = 1'b0;
        vir_mem_reqs_addr[0]     = 32'h0033_4444;
        vir_mem_reqs_data[0]     = '0;
        run_txn(1, 1'b0, 32'h0011_2222, '0, 0, 1'b0, 1'b0, lat);
        run_txn(0, 1'b0, 32'h0033_4444, '0, 0, 1'b0, 1'b0, lat);
    endtask

    task automatic test_stray_resp();
        int lat;
        phy_mem_resps_valid = 1'b1;
        phy_mem_resps_data  = rand_line();
        #1;
        n_cmp++;
        if (phy_mem_resp_grants !== 1'b0) begin
            n_err++;
            $display("FAIL stray_idle_grant: resp_grant=%b required 0", phy_mem_resp_grants);
        end
        @(negedge clk);
        phy_mem_resps_valid = 1'b0;
        #1;
        n_cmp++;
        if (phy_mem_reqs_valid !== 1'b0 || vir_mem_resps_valid !== 2'b00) begin
            n_err++;
            $display("FAIL stray_idle_state: req_v=%b vresp_v=%b required 0 and 00", phy_mem_reqs_valid, vir_mem_resps_valid);
        end
        run_txn(1, 1'b0, 32'h0007_1234, rand_line(), 2, 1'b1, 1'b0, lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        run_txn(1, 1'b0, 32'h0009_0abc, rand_line(), 1, 1'b0, 1'b1, lat);
        run_txn(0, 1'b0, 32'h000a_0def, rand_line(), 0, 1'b0, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 40; i++) begin
            run_txn(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    {11'd0, 5'($urandom_range(31, 0)), 16'($urandom())},
                    rand_line(), int'($urandom_range(2, 0)), 1'b0, 1'b0, lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_read_translation();
        test_write_translation();
        test_back_to_back();
        test_stray_resp();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1);
    end

endmodule
